// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared widths, entry type and default sizing for the instruction buffer.
package inst_buffer_pkg;
    localparam int InstAddrBus   = 32;
    localparam int InstBus       = 32;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_SKID  = 2;
    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } ibuf_entry_t;
endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO of fetched {pc, inst} pairs feeding decode, with early-full
// back-pressure to the PC stage, single-cycle flush and a sticky overflow flag.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SKID  = DEFAULT_SKID
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   icache_valid,
    input  logic [InstAddrBus-1:0] icache_pc,
    input  logic [InstBus-1:0]     icache_inst,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    output logic                   ibuffer_full,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - SKID);
    ibuf_entry_t   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, we;
    assign id_valid     = count_q != '0;
    assign id_pc        = mem_q[head_q].pc;
    assign id_inst      = mem_q[head_q].inst;
    assign ibuffer_full = count_q >= THRESH;
    assign overflow     = overflow_q;
    always_comb begin
        pop        = id_valid && id_ready;
        push       = icache_valid && (count_q < FULL || pop);
        we         = push && !flush;
        head_d     = flush ? '0 : head_q + AW'(pop);
        tail_d     = flush ? '0 : tail_q + AW'(push);
        count_d    = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        // A response arriving alongside a flush is discarded on purpose, not dropped.
        overflow_d = overflow_q | (icache_valid & ~push & ~flush);
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we && resetn) mem_q[tail_q] <= '{pc: icache_pc, inst: icache_inst};
    end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed stimulus for inst_buffer checked every cycle against a queue model,
// plus literal expectations from the hand-worked test plan.
module tb_inst_buffer;
    logic        clk = 0;
    logic        resetn = 0;
    logic        flush = 0;
    logic        icache_valid = 0;
    logic [31:0] icache_pc = 0;
    logic [31:0] icache_inst = 0;
    logic        id_ready = 0;
    logic        id_valid, ibuffer_full, overflow;
    logic [31:0] id_pc, id_inst;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] mq[$];
    logic        m_ovf = 0;
    inst_buffer dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .icache_valid(icache_valid), .icache_pc(icache_pc), .icache_inst(icache_inst),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .ibuffer_full(ibuffer_full), .overflow(overflow)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h0000_0013;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic check_model();
        chk("model id_valid", 32'(id_valid), 32'(mq.size() != 0));
        chk("model ibuffer_full", 32'(ibuffer_full), 32'(mq.size() >= 6));
        chk("model overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk("model id_pc", id_pc, mq[0][63:32]);
            chk("model id_inst", id_inst, mq[0][31:0]);
        end
    endtask
    // One clock: drive inputs, update the model across the edge, compare at the falling edge.
    task automatic cyc(input logic rst_n, input logic fl, input logic v,
                       input logic [31:0] pc, input logic rdy);
        bit do_pop, do_push;
        resetn = rst_n; flush = fl; icache_valid = v; icache_pc = pc;
        icache_inst = inst_of(pc); id_ready = rdy;
        do_pop  = rdy && mq.size() != 0;
        do_push = v && (mq.size() < 8 || do_pop);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
        end else if (fl) mq.delete();
        else begin
            if (v && !do_push) m_ovf = 1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({pc, inst_of(pc)});
        end
        @(negedge clk);
        check_model();
    endtask
    task automatic push(input logic [31:0] pc);
        cyc(1, 0, 1, pc, 0);
    endtask
    task automatic idle();
        cyc(1, 0, 0, 32'h0, 0);
    endtask
    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset id_valid", 32'(id_valid), 0);
        chk("reset ibuffer_full", 32'(ibuffer_full), 0);
        chk("reset overflow", 32'(overflow), 0);
        // Fill to threshold and beyond to full
        for (int i = 0; i < 8; i++) begin
            push(32'hbfc0_0000 + 32'(4 * i));
            chk("fill id_pc", id_pc, 32'hbfc0_0000);
            chk("fill ibuffer_full", 32'(ibuffer_full), 32'(i >= 5));
        end
        // Overflow: dropped push
        push(32'hbfc0_0020);
        chk("overflow set", 32'(overflow), 1);
        idle();
        chk("overflow sticky", 32'(overflow), 1);
        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk("drain order", id_pc, 32'hbfc0_0000 + 32'(4 * i));
            cyc(1, 0, 0, 0, 1);
        end
        chk("drain empty", 32'(id_valid), 0);
        chk("drain overflow kept", 32'(overflow), 1);
        // Pop at full: simultaneous push and pop keep count at DEPTH
        for (int i = 0; i < 8; i++) push(32'h1000_0000 + 32'(4 * i));
        cyc(1, 0, 1, 32'h1000_0100, 1);
        chk("popfull head", id_pc, 32'h1000_0004);
        chk("popfull full", 32'(ibuffer_full), 1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1);
        chk("popfull empty", 32'(id_valid), 0);
        // Flush with simultaneous push/pop
        for (int i = 0; i < 5; i++) push(32'h2000_0000 + 32'(4 * i));
        cyc(1, 1, 1, 32'h2000_0100, 1);
        chk("flush id_valid", 32'(id_valid), 0);
        chk("flush ibuffer_full", 32'(ibuffer_full), 0);
        chk("flush overflow kept", 32'(overflow), 1);
        push(32'h8000_0000);
        chk("post-flush id_pc", id_pc, 32'h8000_0000);
        chk("post-flush id_inst", id_inst, 32'h8000_0013);
        // Steady state push+pop across pointer wrap
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 0, 1, 32'h8000_0000 + 32'(4 * i), 1);
            chk("steady id_pc", id_pc, 32'h8000_0000 + 32'(4 * i));
            chk("steady id_valid", 32'(id_valid), 1);
        end
        // Reset mid-operation
        for (int i = 0; i < 3; i++) push(32'h3000_0000 + 32'(4 * i));
        cyc(0, 0, 0, 0, 0);
        chk("midreset id_valid", 32'(id_valid), 0);
        chk("midreset ibuffer_full", 32'(ibuffer_full), 0);
        chk("midreset overflow", 32'(overflow), 0);
        push(32'h4000_0000);
        chk("after reset id_pc", id_pc, 32'h4000_0000);
        chk("after reset id_valid", 32'(id_valid), 1);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
